axi_rw_arbiter: RTL
===================

Name: axi_rw_arbiter

Overview:
- Sits between the AXI port of the top level and a single-ported AXI-to-backend bridge, such as the AHB, APB or register-file bridge.
- Serialises write and read bursts so that only one burst at a time owns the backend.
- Grants round-robin when both aw and ar requests are pending.
- Holds the grant until the burst completes: the b handshake for a write, the r_last handshake for a read.

Parameters:
- TIMEOUT_CYCLES, 256: cycles a granted burst may hold the backend before a forced release. Used only with the optional feature.
- CNT_W, 9: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- a_clk  in  1  clock
- a_reset  in  1  synchronous active-high reset
- m_aw_valid  in  1  master write-address valid
- m_aw_ready  out  1  master write-address ready
- m_w_valid  in  1  master write-data valid
- m_w_ready  out  1  master write-data ready
- m_b_valid  out  1  master write-response valid
- m_b_ready  in  1  master write-response ready
- m_ar_valid  in  1  master read-address valid
- m_ar_ready  out  1  master read-address ready
- m_r_valid  out  1  master read-data valid
- m_r_last  out  1  master read-data last
- m_r_ready  in  1  master read-data ready
- s_aw_valid  out  1  bridge write-address valid
- s_aw_ready  in  1  bridge write-address ready
- s_w_valid  out  1  bridge write-data valid
- s_w_ready  in  1  bridge write-data ready
- s_b_valid  in  1  bridge write-response valid
- s_b_ready  out  1  bridge write-response ready
- s_ar_valid  out  1  bridge read-address valid
- s_ar_ready  in  1  bridge read-address ready
- s_r_valid  in  1  bridge read-data valid
- s_r_last  in  1  bridge read-data last
- s_r_ready  out  1  bridge read-data ready
- grant_wr  out  1  write burst owns the backend
- grant_rd  out  1  read burst owns the backend
- timeout_err  out  1  sticky flag: a burst was force-released

Payload buses (id, addr, len, size, burst, data, strb, resp) are routed around the block unchanged and are not ports.

Behaviour:
- Reset: one clock, a_reset synchronous and active-high. On reset: state = IDLE, last_grant = RD (so a write wins the first tie), timeout counter = 0, timeout_err = 0. Every s_*valid, s_*ready, m_*valid and m_*ready output is 0; grant_wr = grant_rd = 0.
- States: IDLE, WR_ADDR, WR_BUSY, RD_ADDR, RD_BUSY.
- IDLE:
  - m_aw_valid only -> WR_ADDR.
  - m_ar_valid only -> RD_ADDR.
  - Both -> the side opposite last_grant; last_grant updates to the chosen side.
  - Neither -> stay in IDLE.
  - Grant is registered: one cycle from request to s_*valid.
- WR_ADDR: s_aw_valid = m_aw_valid and m_aw_ready = s_aw_ready. On the aw handshake -> WR_BUSY.
- Write data: the w channel passes through (s_w_valid = m_w_valid, m_w_ready = s_w_ready) in WR_ADDR and WR_BUSY. Outside those states s_w_valid = 0 and m_w_ready = 0.
- WR_BUSY: the b channel passes through. On s_b_valid & m_b_ready -> IDLE.
- RD_ADDR: the ar channel passes through. On the ar handshake -> RD_BUSY.
- RD_BUSY: the r channel passes through. On s_r_valid & m_r_ready & s_r_last -> IDLE.
- Channel gating: all channel gating is combinational from state. Any channel not owned has its valid and ready forced to 0.
- Derived outputs: grant_wr = state ∈ {WR_ADDR, WR_BUSY}; grant_rd = state ∈ {RD_ADDR, RD_BUSY}.
- No back-to-back grant: return to IDLE costs one idle cycle between bursts. The idle cycle is required.
- Request held during the other burst: a request pending while the other side is busy is held by the master per AXI rules. It wins at the next IDLE.
- Non-starvation: a continuously held request from either side is granted within one burst of the other side.
- Reset mid-burst: returns to IDLE immediately and drops all gated valid/ready signals. No partial handshake completes.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- When defined:
  - The counter clears on entry to any non-IDLE state and increments each cycle in a non-IDLE state.
  - When the counter reaches TIMEOUT_CYCLES-1 without completion: next state = IDLE and timeout_err is set.
  - timeout_err is sticky and cleared only by a_reset.
  - A completing handshake on the same cycle as the timeout wins; timeout_err stays unchanged.
- When undefined: no counter is built, timeout_err is tied to 0, and a granted burst holds the backend indefinitely.

Test Plan:
- Single write: aw, then a len=3 burst of 4 w beats, then b -> grant_wr for exactly that span; ar stays gated (m_ar_ready = 0); back to IDLE one cycle after the b handshake.
- Simultaneous m_aw_valid and m_ar_valid after reset -> write granted first. After b, one IDLE cycle, then read granted. Next tie -> write again.
- Read burst len=7 with m_r_ready toggled every other cycle -> 8 beats pass through and grant is released only on the beat with s_r_last.
- m_ar_valid raised during WR_BUSY -> s_ar_valid stays 0 until the write completes; read granted two cycles after the b handshake.
- a_reset pulsed in RD_BUSY mid-burst -> next cycle all outputs 0 and state IDLE; a fresh write is then granted normally.
- With ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16: write granted, s_b_valid never asserted -> forced IDLE after 16 cycles and timeout_err = 1 until reset. Without the macro -> grant held, timeout_err = 0.

Source files
------------

// File: rtl/axi_rw_arbiter.sv
// Single-owner AXI arbiter: serialises write and read bursts onto one backend bridge.
// Optional forced-release timeout is enabled by defining ARB_TIMEOUT_EN.
module axi_rw_arbiter #(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CNT_W          = 9
) (
  input  logic a_clk,
  input  logic a_reset,
  input  logic m_aw_valid,
  output logic m_aw_ready,
  input  logic m_w_valid,
  output logic m_w_ready,
  output logic m_b_valid,
  input  logic m_b_ready,
  input  logic m_ar_valid,
  output logic m_ar_ready,
  output logic m_r_valid,
  output logic m_r_last,
  input  logic m_r_ready,
  output logic s_aw_valid,
  input  logic s_aw_ready,
  output logic s_w_valid,
  input  logic s_w_ready,
  input  logic s_b_valid,
  output logic s_b_ready,
  output logic s_ar_valid,
  input  logic s_ar_ready,
  input  logic s_r_valid,
  input  logic s_r_last,
  output logic s_r_ready,
  output logic grant_wr,
  output logic grant_rd,
  output logic timeout_err
);

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR,
    WR_BUSY,
    RD_ADDR,
    RD_BUSY
  } state_e;

  state_e state_q, state_d;
  // last_rd_q = 1 means the read side received the most recent grant
  logic   last_rd_q, last_rd_d;

`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_err_q, timeout_err_d;
  logic             burst_done;
`endif

  always_ff @(posedge a_clk) begin
    if (a_reset) begin
      state_q   <= IDLE;
      last_rd_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      last_rd_q <= last_rd_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge a_clk) begin
    if (a_reset) begin
      cnt_q         <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign timeout_err = timeout_err_q;
`else
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    last_rd_d = last_rd_q;
`ifdef ARB_TIMEOUT_EN
    cnt_d         = '0;
    timeout_err_d = timeout_err_q;
    burst_done    = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        // On a tie the side that did not win last time is chosen
        if (m_aw_valid && (!m_ar_valid || last_rd_q)) begin
          state_d   = WR_ADDR;
          last_rd_d = 1'b0;
        end else if (m_ar_valid) begin
          state_d   = RD_ADDR;
          last_rd_d = 1'b1;
        end
      end
      WR_ADDR: if (m_aw_valid && s_aw_ready) state_d = WR_BUSY;
      WR_BUSY: if (s_b_valid && m_b_ready) state_d = IDLE;
      RD_ADDR: if (m_ar_valid && s_ar_ready) state_d = RD_BUSY;
      RD_BUSY: if (s_r_valid && m_r_ready && s_r_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
`ifdef ARB_TIMEOUT_EN
    burst_done = ((state_q == WR_BUSY) && s_b_valid && m_b_ready) ||
                 ((state_q == RD_BUSY) && s_r_valid && m_r_ready && s_r_last);
    // A completing handshake on the last allowed cycle takes priority over the timeout
    if (state_q != IDLE) begin
      if ((cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) && !burst_done) begin
        state_d       = IDLE;
        timeout_err_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
`endif
  end

  always_comb begin
    m_aw_ready = 1'b0;
    m_w_ready  = 1'b0;
    m_b_valid  = 1'b0;
    m_ar_ready = 1'b0;
    m_r_valid  = 1'b0;
    m_r_last   = 1'b0;
    s_aw_valid = 1'b0;
    s_w_valid  = 1'b0;
    s_b_ready  = 1'b0;
    s_ar_valid = 1'b0;
    s_r_ready  = 1'b0;
    grant_wr   = 1'b0;
    grant_rd   = 1'b0;
    unique case (state_q)
      WR_ADDR: begin
        s_aw_valid = m_aw_valid;
        m_aw_ready = s_aw_ready;
        s_w_valid  = m_w_valid;
        m_w_ready  = s_w_ready;
        grant_wr   = 1'b1;
      end
      WR_BUSY: begin
        s_w_valid  = m_w_valid;
        m_w_ready  = s_w_ready;
        m_b_valid  = s_b_valid;
        s_b_ready  = m_b_ready;
        grant_wr   = 1'b1;
      end
      RD_ADDR: begin
        s_ar_valid = m_ar_valid;
        m_ar_ready = s_ar_ready;
        grant_rd   = 1'b1;
      end
      RD_BUSY: begin
        m_r_valid  = s_r_valid;
        m_r_last   = s_r_last;
        s_r_ready  = m_r_ready;
        grant_rd   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
